// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that sequences a single-port-style RAM (write and read never
// share a cycle) with ready/valid upstream and request/ack downstream handshakes.
module ram_fifo_ctrl #(
  parameter int RAM_width    = 8,
  parameter int RAM_depth    = 256,
  parameter int address_size = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [RAM_width-1:0]    in_data,
  output logic                    in_ready,
  input  logic                    rd_req,
  output logic                    rd_ack,
  output logic                    out_valid,
  output logic                    ram_write_enable,
  output logic                    ram_read_enable,
  output logic [address_size-1:0] ram_write_address,
  output logic [address_size-1:0] ram_read_address,
  output logic [RAM_width-1:0]    ram_data_in,
  output logic                    full,
  output logic                    empty,
  output logic [address_size:0]   count
);

  localparam logic [address_size-1:0] PTR_ONE   = address_size'(1);
  localparam logic [address_size:0]   CNT_ONE   = (address_size + 1)'(1);
  localparam logic [address_size:0]   CNT_DEPTH = (address_size + 1)'(RAM_depth);

  logic [address_size-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_size-1:0] rd_ptr_q, rd_ptr_d;
  logic [address_size:0]   count_q, count_d;
  logic                    prio_q, prio_d;
  logic                    out_valid_q, out_valid_d;

  logic wr_want, rd_want, write, read;

  // Arbitration: the RAM drops reads during writes, so only one side may win.
  always_comb begin
    full    = (count_q == CNT_DEPTH);
    empty   = (count_q == '0);
    wr_want = in_valid && !full && !reset;
    rd_want = rd_req && !empty;
    write   = wr_want && (!rd_want || prio_q);
    read    = rd_want && (!wr_want || !prio_q);

    in_ready = !reset && !full && (!rd_want || prio_q);
    rd_ack   = !empty && (!wr_want || !prio_q);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    prio_d      = prio_q;
    out_valid_d = read;

    if (write) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (read)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (write)     count_d = count_q + CNT_ONE;
    else if (read) count_d = count_q - CNT_ONE;

    // Flip only on contention so competing requesters take turns.
    if (wr_want && rd_want) prio_d = !prio_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ram_write_enable  = write;
  assign ram_read_enable   = read;
  assign ram_write_address = wr_ptr_q;
  assign ram_read_address  = rd_ptr_q;
  assign ram_data_in       = in_data;
  assign out_valid         = out_valid_q;
  assign count             = count_q;

endmodule
